// File: rtl/rgb_led_pkg.sv
// Purpose: shared constants and types for the RGB LED PWM driver/decoder pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: frame length default, blink timeout default, per-channel count
// width, packed colour triple and the blink-detector state encoding.
package rgb_led_pkg;

    // One PWM frame, and therefore one decoder measurement window, in clk cycles.
    localparam int          PWM_STEPS_DEF     = 255;

    // Window ends without a dark/lit change before blink is withdrawn
    // (about 1.0 s of 255-cycle windows at 27 MHz).
    localparam logic [16:0] BLINK_TIMEOUT_DEF = 17'd105882;

    // Per-channel duty count width; 255 steps fit exactly in 8 bits.
    localparam int          CNT_W             = 8;

    typedef struct packed {
        logic [CNT_W-1:0] r;
        logic [CNT_W-1:0] g;
        logic [CNT_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        STEADY   = 2'd0,
        ONE_EDGE = 2'd1,
        BLINKING = 2'd2
    } blink_state_t;

endpackage

// File: rtl/pwm_duty_counter.sv
// Purpose: measure the low-time of one active-low PWM line over a measurement window.
// Latency: 2-cycle synchroniser, count loads on the window-end edge.
// Backpressure: none; count is overwritten every window.
//
// Ports:
//   clk, n_rst  clock and asynchronous active-low reset
//   pwm_n       raw active-low PWM line (asynchronous to nothing in particular)
//   win_end     high during the last cycle of each window, from the top
//   count_nxt   value the count will take if this is the window-end cycle
//   count       duty count of the last completed window
module pwm_duty_counter
    import rgb_led_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             pwm_n,
    input  logic             win_end,
    output logic [CNT_W-1:0] count_nxt,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q1;
    logic             sync_q2;
    logic             low;
    logic [CNT_W-1:0] acc;

    // Synchronised sample; the line is active-low so 0 means light on.
    assign low = ~sync_q2;

    // The window-end sample is folded in here rather than into acc, so a
    // fully-on window yields 255 without acc ever needing a ninth bit.
    assign count_nxt = acc + {{(CNT_W-1){1'b0}}, low};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            acc     <= '0;
            count   <= '0;
        end else begin
            sync_q1 <= pwm_n;
            sync_q2 <= sync_q1;
            if (win_end) begin
                count <= count_nxt;
                acc   <= '0;
            end else if (low) begin
                acc <= acc + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/rgb_pwm_decoder.sv
// Purpose: recover the RGB duty value from three active-low PWM lines, flag dark and blinking.
// Latency: 2-cycle input sync; outputs update on the edge ending each PWM_STEPS-cycle window.
// Backpressure: none; rgb_valid is a one-cycle pulse that cannot be stalled.
//
// Ports:
//   clk, n_rst           clock and asynchronous active-low reset
//   led_r, led_g, led_b  active-low PWM lines (0 = light on)
//   rgb                  {r,g,b} duty counts of the last window
//   rgb_valid            pulse for the cycle following each rgb update
//   lit_rgb              last measurement taken with two consecutive lit windows
//   dark                 last window had all three counts zero
//   blink                dark/lit alternation detected
module rgb_pwm_decoder
    import rgb_led_pkg::*;
#(
    parameter int          PWM_STEPS     = PWM_STEPS_DEF,
    parameter logic [16:0] BLINK_TIMEOUT = BLINK_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        led_r,
    input  logic        led_g,
    input  logic        led_b,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    output logic [23:0] lit_rgb,
    output logic        dark,
    output logic        blink
);

    localparam int               WIN_W    = (PWM_STEPS > 2) ? $clog2(PWM_STEPS) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PWM_STEPS - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [16:0]      TMR_ONE  = 17'd1;

    // ------------------------------------------------------------------
    // Free-running window counter. No alignment to the driver is needed:
    // any PWM_STEPS consecutive samples of a periodic frame hold the duty.
    // ------------------------------------------------------------------
    logic [WIN_W-1:0] win;
    logic             win_end;

    assign win_end = (win == WIN_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win <= '0;
        end else if (win_end) begin
            win <= '0;
        end else begin
            win <= win + WIN_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel duty counters
    // ------------------------------------------------------------------
    rgb_t cnt_nxt;
    rgb_t cnt_q;

    pwm_duty_counter u_cnt_r (
        .clk       (clk),
        .n_rst     (n_rst),
        .pwm_n     (led_r),
        .win_end   (win_end),
        .count_nxt (cnt_nxt.r),
        .count     (cnt_q.r)
    );

    pwm_duty_counter u_cnt_g (
        .clk       (clk),
        .n_rst     (n_rst),
        .pwm_n     (led_g),
        .win_end   (win_end),
        .count_nxt (cnt_nxt.g),
        .count     (cnt_q.g)
    );

    pwm_duty_counter u_cnt_b (
        .clk       (clk),
        .n_rst     (n_rst),
        .pwm_n     (led_b),
        .win_end   (win_end),
        .count_nxt (cnt_nxt.b),
        .count     (cnt_q.b)
    );

    assign rgb = cnt_q;

    // ------------------------------------------------------------------
    // Window classification and stable-lit capture.
    // dark_q doubles as the previous window's class: it is loaded with the
    // class of the window just ended, on the same edge as rgb.
    // ------------------------------------------------------------------
    logic win_dark;
    logic transition;
    logic dark_q;
    logic valid_q;
    rgb_t lit_q;

    assign win_dark   = (cnt_nxt == '0);
    assign transition = (win_dark != dark_q);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dark_q  <= 1'b1;
            valid_q <= 1'b0;
            lit_q   <= '0;
        end else begin
            valid_q <= win_end;
            if (win_end) begin
                dark_q <= win_dark;
                // A window next to a dark one may hold only part of a lit
                // frame, so only a lit window following a lit window is kept.
                if (!win_dark && !dark_q) begin
                    lit_q <= cnt_nxt;
                end
            end
        end
    end

    assign rgb_valid = valid_q;
    assign dark      = dark_q;
    assign lit_rgb   = lit_q;

    // ------------------------------------------------------------------
    // Blink detector: two transitions close together mean blinking; a
    // long enough quiet spell returns to steady. The timer counts quiet
    // windows and saturates at BLINK_TIMEOUT. A transition always wins
    // over a timeout falling in the same window.
    // ------------------------------------------------------------------
    blink_state_t state;
    blink_state_t state_nxt;
    logic [16:0]  timer;
    logic [16:0]  timer_nxt;
    logic         blink_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= STEADY;
            timer   <= '0;
            blink_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            blink_q <= (state_nxt == BLINKING);
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (win_end) begin
            if (transition) begin
                timer_nxt = '0;
                case (state)
                    STEADY:   state_nxt = ONE_EDGE;
                    ONE_EDGE: state_nxt = BLINKING;
                    BLINKING: state_nxt = BLINKING;
                    default:  state_nxt = STEADY;
                endcase
            end else if (timer == BLINK_TIMEOUT) begin
                // Saturated: hold the timer, fall back to steady.
                state_nxt = STEADY;
            end else begin
                timer_nxt = timer + TMR_ONE;
            end
        end
    end

    assign blink = blink_q;

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Purpose: scoreboard bench for rgb_pwm_decoder against a sample-history reference model.
// Latency: expected windows are due PWM_STEPS cycles after each window start.
// Backpressure: n/a.
module tb_rgb_pwm_decoder;

    localparam int STEPS = 255;
    localparam int TO    = 20;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        led_r, led_g, led_b;
    logic [23:0] rgb, lit_rgb;
    logic        rgb_valid, dark, blink;

    rgb_pwm_decoder #(
        .PWM_STEPS     (STEPS),
        .BLINK_TIMEOUT (17'(TO))
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .led_r     (led_r),
        .led_g     (led_g),
        .led_b     (led_b),
        .rgb       (rgb),
        .rgb_valid (rgb_valid),
        .lit_rgb   (lit_rgb),
        .dark      (dark),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic        dark;
        logic [23:0] lit;
        logic        blink;
        int          due;
    } exp_t;

    exp_t        sb[$];      // expected window results, oldest first
    logic [2:0]  hist[$];    // line values {r,g,b} driven in cycle k since reset release
    int          trans[$];   // window indices at which dark/lit class changed
    logic        m_prev_dark;
    logic [23:0] m_lit;
    int          cyc;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        e;

    // Cycle index since reset release; window w spans cycles w*STEPS .. w*STEPS+STEPS-1.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        hist.delete();
        trans.delete();
        m_prev_dark = 1'b1;
        m_lit       = 24'h0;
    endtask

    // Record the value driven in the current cycle. Once the last input a
    // window depends on is known, compute that window's expected outcome.
    // The decoder sees each input two cycles late, so window w counts the
    // low samples among inputs w*STEPS-2 .. w*STEPS+STEPS-3 (earlier = off).
    task automatic record(input logic [2:0] v);
        int         j, w, r, g, b, nt;
        logic [2:0] s;
        logic       nd;
        exp_t       x;
        hist.push_back(v);
        j = hist.size() - 1;
        if (j >= STEPS - 3 && ((j - (STEPS - 3)) % STEPS) == 0) begin
            w = (j - (STEPS - 3)) / STEPS;
            r = 0; g = 0; b = 0;
            for (int k = w * STEPS - 2; k <= w * STEPS + STEPS - 3; k++) begin
                s = (k < 0) ? 3'b111 : hist[k];
                if (!s[2]) r++;
                if (!s[1]) g++;
                if (!s[0]) b++;
            end
            nd = (r + g + b == 0);
            if (!nd && !m_prev_dark) m_lit = {r[7:0], g[7:0], b[7:0]};
            if (nd != m_prev_dark) trans.push_back(w);
            m_prev_dark = nd;
            // Blinking: the latest change came no more than TO quiet windows
            // ago, and it followed an earlier change closely enough that the
            // detector had not yet given up (at most TO+1 windows apart).
            nt = trans.size();
            x.blink = (nt >= 2) && ((w - trans[nt-1]) <= TO) &&
                      ((trans[nt-1] - trans[nt-2]) <= TO + 1);
            x.rgb  = {r[7:0], g[7:0], b[7:0]};
            x.dark = nd;
            x.lit  = m_lit;
            x.due  = (w + 1) * STEPS;
            sb.push_back(x);
        end
    endtask

    function automatic logic [2:0] pwm_lines(input logic [23:0] col, input int ph);
        logic [2:0] v;
        v[2] = (ph < int'(col[23:16])) ? 1'b0 : 1'b1;
        v[1] = (ph < int'(col[15:8]))  ? 1'b0 : 1'b1;
        v[0] = (ph < int'(col[7:0]))   ? 1'b0 : 1'b1;
        return v;
    endfunction

    // Drive an LED-driver waveform: frames start when cyc-off is a multiple
    // of STEPS; the first lit_n frames of every lit_n+dark_n are lit, the rest
    // are all-high. dark_n = 0 means permanently lit.
    task automatic drive_pattern(input logic [23:0] col, input int off,
                                 input int lit_n, input int dark_n, input int ncyc);
        int         f0, rel, frame, ph;
        logic       on;
        logic [2:0] v;
        f0 = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            rel   = cyc - off + STEPS * 1000;
            frame = rel / STEPS;
            ph    = rel % STEPS;
            if (f0 < 0) f0 = frame;
            on = (dark_n == 0) || (((frame - f0) % (lit_n + dark_n)) < lit_n);
            v  = on ? pwm_lines(col, ph) : 3'b111;
            {led_r, led_g, led_b} = v;
            record(v);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rgb"},       32'(rgb),       32'h0);
        chk({tag, "_lit_rgb"},   32'(lit_rgb),   32'h0);
        chk({tag, "_rgb_valid"}, 32'(rgb_valid), 32'h0);
        chk({tag, "_dark"},      32'(dark),      32'h1);
        chk({tag, "_blink"},     32'(blink),     32'h0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        n_rst = 1'b1;
        record({led_r, led_g, led_b});
    endtask

    // Monitor: every window outcome must appear exactly on its due cycle.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rgb_valid", 32'(rgb_valid), 32'h1);
                chk("rgb",       32'(rgb),       32'(e.rgb));
                chk("dark",      32'(dark),      32'(e.dark));
                chk("lit_rgb",   32'(lit_rgb),   32'(e.lit));
                chk("blink",     32'(blink),     32'(e.blink));
            end else if (rgb_valid) begin
                n_vec++;
                n_err++;
                $display("FAIL rgb_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        logic [23:0] col;
        n_rst = 1'b0;
        {led_r, led_g, led_b} = 3'b111;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("init");
        release_rst();

        // Steady colour, then the same colour at a different frame phase.
        drive_pattern(24'h8000FF, 0,   1, 0, 6 * STEPS);
        drive_pattern(24'h8000FF, 100, 1, 0, 6 * STEPS);
        // All lines off: dark, lit_rgb retained.
        drive_pattern(24'h000000, 0,   1, 0, 4 * STEPS);
        // Blinking 10 lit / 10 dark, frames aligned to the sampled windows.
        drive_pattern(24'h10FF01, STEPS - 2, 10, 10, 60 * STEPS);
        // Steady lit afterwards: blink must time out.
        drive_pattern(24'h10FF01, STEPS - 2, 1, 0, 30 * STEPS);
        // Single-cycle pulses and fully-on lines.
        drive_pattern(24'h010101, 37, 1, 0, 4 * STEPS);
        drive_pattern(24'hFFFFFF, 0,  1, 0, 4 * STEPS);

        // Random colours, phases and blink patterns.
        for (int i = 0; i < 6; i++) begin
            col = 24'($urandom);
            if ($urandom_range(0, 3) == 0) col[15:8] = 8'h00;
            drive_pattern(col, int'($urandom_range(0, STEPS - 1)),
                          int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                          5 * STEPS);
        end

        // Reset in the middle of a window during a steady colour.
        drive_pattern(24'h404040, 0, 1, 0, 2 * STEPS);
        for (int k = 0; k < 2 * STEPS && (cyc % STEPS) != 99; k++)
            drive_pattern(24'h404040, 0, 1, 0, 1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        repeat (3) @(negedge clk);
        release_rst();
        drive_pattern(24'h404040, 0, 1, 0, 3 * STEPS + 5);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_decoder.md
# rgb_pwm_decoder

Receive-side counterpart of the RGB LED PWM driver. Samples three active-low 255-step PWM lines and recovers the 8-bit-per-channel RGB duty value. It also flags whether the lines are dark or lit and whether they are blinking. It sits on the board-test and loopback path, next to the LED driver, and its decoded value is compared against the commanded colour.

## Interface
Parameters:
- PWM_STEPS, 255, PWM frame length in clk cycles; also the measurement window length.
- BLINK_TIMEOUT, 17'd105882, windows without a dark/lit transition before blink drops (about 1.0 s at 27 MHz).

Ports:
- clk  in  1  system clock, 27 MHz.
- n_rst  in  1  reset, asynchronous, active-low.
- led_r  in  1  red PWM line, active-low (0 = light on).
- led_g  in  1  green PWM line, active-low.
- led_b  in  1  blue PWM line, active-low.
- rgb  out  24  last window's duty counts, {r,g,b}, 8 bits each.
- rgb_valid  out  1  one-cycle pulse, coincident with each rgb update.
- lit_rgb  out  24  last stable lit measurement.
- dark  out  1  last window had all three counts = 0.
- blink  out  1  dark/lit alternation detected.

## Operation
- **Input synchronisation:** each line passes through a 2-flop synchroniser, reset value 1 (off).
- **Window counter:** win counts 0..PWM_STEPS-1 and wraps to 0. It is free-running and needs no alignment to the driver. Any 255 consecutive samples of a periodic 255-step PWM contain exactly the duty count.
- **Accumulation:** per channel, the 8-bit acc increments on every cycle the synchronised line is 0.
- **Window end (win==254):**
  - rgb channel <= acc + (current sample low), so the last sample is included.
  - acc <= 0.
  - The maximum value is 255 (full on). All-high input gives 0 (full off). No overflow is possible.
- **Window classification:** dark = (all three new counts == 0); lit = not dark. dark registers with rgb.
- **lit_rgb update:** only when the current and the previous window are both lit. This rejects the partial window that straddles a blink edge.
- **Transition:** window class differs from the previous window's class.
- **Blink FSM:** states STEADY, ONE_EDGE, BLINKING; 17-bit window timer, saturating at BLINK_TIMEOUT.
  - STEADY: transition -> ONE_EDGE, timer <= 0.
  - ONE_EDGE: transition -> BLINKING, timer <= 0; timer == BLINK_TIMEOUT -> STEADY.
  - BLINKING: transition -> timer <= 0, stay; timer == BLINK_TIMEOUT -> STEADY.
  - The timer increments once per window end when no transition occurs.
  - blink = (state == BLINKING), registered.
- **Reset:** reset mid-window discards the partial accumulation. The window restarts at win=0 after release.

## Timing
- Reset values: rgb=0, lit_rgb=0, rgb_valid=0, dark=1, blink=0, state=STEADY, win=0, acc=0, timer=0, synchroniser flops=1.
- Input-to-sample latency: 2 cycles.
- rgb, dark and lit_rgb update on the clk edge that ends the win==254 cycle. rgb_valid is high for exactly the following cycle.
- The previous-window class is also reset to dark.
- After n_rst release:
  - The first rgb_valid appears 255 cycles later.
  - The first correct full-frame value appears no later than the second rgb_valid, because of synchroniser latency and the initial phase.
- blink changes at window-end edges only.
- A transition and a timeout in the same window: the transition wins and the timer clears.

## Structure
- Shared package rgb_led_pkg holds:
  - the PWM_STEPS default (255);
  - the BLINK_TIMEOUT default;
  - the blink state enum {STEADY, ONE_EDGE, BLINKING}.
- Sub-module pwm_duty_counter, instantiated three times. Per channel it holds the synchroniser, the acc, and the count output at window end. It takes win_end from the top.
- The top holds the window counter, classification, lit_rgb and the blink FSM.

## Test plan
- Driver model at rgb=0x8000FF, blink off: from the second rgb_valid on, rgb=0x8000FF every 255 cycles, lit_rgb=0x8000FF, dark=0, blink=0.
- Same stimulus started 100 cycles offset from the decoder window: identical rgb values, proving phase independence.
- All lines held high: rgb=0x000000, dark=1, lit_rgb keeps its prior value (0x8000FF), blink=0.
- BLINK_TIMEOUT=20, driver rgb=0x10FF01, alternating 10 lit / 10 dark windows:
  - blink asserts on the second transition;
  - lit_rgb=0x10FF01, never a partial value;
  - then hold steady lit: blink drops after 20 windows with no transition.
- One 1-cycle low pulse per frame on each line: rgb=0x010101. Lines held low continuously: rgb=0xFFFFFF.
- n_rst asserted at win=100 during steady 0x404040: all outputs at reset values immediately; after release, the first rgb_valid comes 255 cycles later and the second carries 0x404040.
